// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable counter: FSM states, count modes and
// the per-cycle command decode that resolves control-input priority.
package prog_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RSVD    = 2'b11;

  // One winning action per cycle, in priority order clear > load > stop > start > step.
  typedef enum logic [2:0] {
    CMD_HOLD  = 3'd0,
    CMD_CLEAR = 3'd1,
    CMD_LOAD  = 3'd2,
    CMD_STOP  = 3'd3,
    CMD_START = 3'd4,
    CMD_STEP  = 3'd5
  } cmd_t;

  function automatic cmd_t decode_cmd(
    input logic clear,
    input logic load,
    input logic stop,
    input logic start,
    input logic in_run
  );
    cmd_t c;
    c = CMD_HOLD;
    if (clear)               c = CMD_CLEAR;
    else if (load)           c = CMD_LOAD;
    else if (stop)           c = CMD_STOP;
    else if (start && !in_run) c = CMD_START;
    else if (in_run)         c = CMD_STEP;
    return c;
  endfunction

endpackage

// File: rtl/prog_counter_tick_gen.sv
// Prescaler: counts enabled cycles 0..prescale and ticks on the last one.
// Holds while en=0; clr restarts from 0 and suppresses the tick.
module tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;
  logic             w_at_end;

  // >= rather than == so a prescale lowered mid-period ticks at once instead of wrapping the field.
  assign w_at_end = (r_cnt >= prescale);
  assign tick     = en & ~clr & w_at_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_at_end ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaler, WRAP/SAT/ONESHOT terminal behaviour
// and an IDLE/RUN/DONE control FSM; count and wrap_pulse are registered, tc is combinational.
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap_pulse,
  output logic             running,
  output logic             done
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;

  cmd_t             w_cmd;
  logic             w_tick;
  logic             w_pre_clr;
  logic             w_pre_en;
  logic             w_tc;

  assign w_cmd = decode_cmd(clear, load, stop, start, r_state == ST_RUN);

  // Any non-step action restarts the prescale period.
  assign w_pre_clr = (w_cmd == CMD_CLEAR) || (w_cmd == CMD_LOAD) ||
                     (w_cmd == CMD_STOP)  || (w_cmd == CMD_START);
  assign w_pre_en  = (w_cmd == CMD_STEP) && en;

  tick_gen #(
    .PRE_W(PRE_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (w_pre_clr),
    .en      (w_pre_en),
    .prescale(prescale),
    .tick    (w_tick)
  );

  // Up-count is terminal at or above limit so a loaded value past limit never runs on.
  assign w_tc = dir ? (r_count >= limit) : (r_count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    unique case (w_cmd)
      CMD_CLEAR: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
      CMD_LOAD:  w_count_nxt = load_val;
      CMD_STOP:  w_state_nxt = ST_IDLE;
      CMD_START: w_state_nxt = ST_RUN;
      CMD_STEP: begin
        if (w_tick) begin
          w_wrap_nxt = w_tc;
          if (!w_tc) begin
            w_count_nxt = dir ? r_count + 1'b1 : r_count - 1'b1;
          end else begin
            unique case (mode)
              MODE_SAT:     w_count_nxt = r_count;
              MODE_ONESHOT: w_state_nxt = ST_DONE;
              default:      w_count_nxt = dir ? '0 : limit;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  assign count      = r_count;
  assign tc         = w_tc;
  assign wrap_pulse = r_wrap;
  assign running    = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboarded bench: stimulus predicts each cycle's outputs from a behavioural model,
// an independent negedge monitor pops and compares.
module tb_prog_counter;

  localparam int WIDTH = 8;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             clear = 1'b0, start = 1'b0, stop = 1'b0, en = 1'b0, dir = 1'b1, load = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] load_val = '0, limit = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [WIDTH-1:0] count;
  logic             tc, wrap_pulse, running, done;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start(start), .stop(stop),
    .en(en), .dir(dir), .mode(mode), .load(load), .load_val(load_val),
    .limit(limit), .prescale(prescale), .count(count), .tc(tc),
    .wrap_pulse(wrap_pulse), .running(running), .done(done)
  );

  typedef struct {
    int count;
    bit tc;
    bit wp;
    bit run;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_count = 0;
  int m_pre   = 0;
  bit m_run   = 0;
  bit m_done  = 0;
  bit m_wp    = 0;

  function automatic void chk(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endfunction

  function automatic bit term_now();
    if (dir) return m_count >= int'(limit);
    return m_count == 0;
  endfunction

  task automatic model_edge();
    bit nwp = 0;
    if (clear) begin
      m_count = 0; m_pre = 0; m_run = 0; m_done = 0;
    end else if (load) begin
      m_count = int'(load_val); m_pre = 0;
    end else if (stop) begin
      m_run = 0; m_done = 0; m_pre = 0;
    end else if (start && !m_run) begin
      m_run = 1; m_done = 0; m_pre = 0;
    end else if (m_run && en) begin
      if (m_pre < int'(prescale)) begin
        m_pre++;
      end else begin
        m_pre = 0;
        if (term_now()) begin
          nwp = 1;
          if (mode == 2'b01) begin
            // saturate: hold
          end else if (mode == 2'b10) begin
            m_run = 0; m_done = 1;
          end else begin
            m_count = dir ? 0 : int'(limit);
          end
        end else begin
          m_count = dir ? m_count + 1 : m_count - 1;
        end
      end
    end
    m_count = m_count % 256;
    m_wp = nwp;
  endtask

  // Called at posedge+1 with this cycle's inputs applied.
  task automatic step_cycle();
    exp_t e;
    if (!reset_n) begin
      m_count = 0; m_pre = 0; m_run = 0; m_done = 0; m_wp = 0;
    end
    e.count = m_count;
    e.tc    = term_now();
    e.wp    = m_wp;
    e.run   = m_run;
    e.done  = m_done;
    exp_q.push_back(e);
    if (reset_n) model_edge();
    @(posedge clk);
    #1;
    clear = 0; load = 0; stop = 0; start = 0;
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count",      int'(count),      e.count);
      chk("tc",         int'(tc),         int'(e.tc));
      chk("wrap_pulse", int'(wrap_pulse), int'(e.wp));
      chk("running",    int'(running),    int'(e.run));
      chk("done",       int'(done),       int'(e.done));
    end
  end

  initial begin
    @(posedge clk);
    #1;
    cycles(2);                       // reset held: all-zero outputs
    reset_n = 1;

    // WRAP up, limit 5, prescale 0
    mode = 2'b00; dir = 1; limit = 5; prescale = 0; en = 1;
    start = 1; step_cycle();
    cycles(9);

    // SAT down from 2 with prescale 2
    stop = 1; step_cycle();
    mode = 2'b01; dir = 0; prescale = 2;
    load = 1; load_val = 2; step_cycle();
    start = 1; step_cycle();
    cycles(14);

    // ONESHOT up to 3, then restart from the held count
    clear = 1; step_cycle();
    mode = 2'b10; dir = 1; limit = 3; prescale = 0;
    start = 1; step_cycle();
    cycles(6);
    start = 1; step_cycle();
    cycles(3);

    // priority: clear beats load and start; load mid-RUN blocks the step
    clear = 1; load = 1; load_val = 9; start = 1; step_cycle();
    mode = 2'b00; limit = 20;
    load = 1; load_val = 7; step_cycle();
    start = 1; step_cycle();
    load = 1; load_val = 2; step_cycle();
    cycles(3);

    // loaded above limit counting up: terminal, wraps to 0
    load = 1; load_val = 200; limit = 10; step_cycle();
    cycles(3);

    // async reset mid-RUN at count 4 with prescaler in progress
    clear = 1; step_cycle();
    limit = 9; prescale = 1;
    start = 1; step_cycle();
    for (int i = 0; i < 40 && m_count != 4; i++) step_cycle();
    step_cycle();
    reset_n = 0; step_cycle();
    step_cycle();
    reset_n = 1; step_cycle();
    start = 1; step_cycle();
    cycles(6);

    // limit 0 counting up: terminal every tick
    limit = 0; prescale = 0; clear = 1; step_cycle();
    start = 1; step_cycle();
    cycles(4);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (!reset_n) reset_n = 1;
      else if (r == 0) reset_n = 0;
      clear = (r >= 1 && r < 3);
      load  = (r >= 3 && r < 7);
      stop  = (r >= 7 && r < 10);
      start = (r >= 10 && r < 22);
      en    = ($urandom_range(0, 9) != 0);
      load_val = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 29) == 0) begin
        mode     = 2'($urandom_range(0, 3));
        dir      = 1'($urandom_range(0, 1));
        limit    = WIDTH'($urandom_range(0, 15));
        prescale = PRE_W'($urandom_range(0, 3));
      end
      step_cycle();
    end

    chk("queue_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, count register width (>=2).
REQ-002 SHALL have parameter PRE_W, default 4, prescale field width (>=1).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clear  in  1  synchronous clear, highest functional priority.
REQ-006 SHALL have port start  in  1  enter RUN from IDLE or DONE.
REQ-007 SHALL have port stop  in  1  return to IDLE from any state.
REQ-008 SHALL have port en  in  1  count enable, qualifies prescaler and step.
REQ-009 SHALL have port dir  in  1  1 = up, 0 = down.
REQ-010 SHALL have port mode  in  2  00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP).
REQ-011 SHALL have port load, load_val  in  1, WIDTH  synchronous parallel load.
REQ-012 SHALL have port limit  in  WIDTH  terminal value for up counting and reload value for down wrap.
REQ-013 SHALL have port prescale  in  PRE_W  step every prescale+1 enabled RUN cycles.
REQ-014 SHALL have port count  out  WIDTH  registered count.
REQ-015 SHALL have port tc  out  1  combinational terminal flag: dir=1 -> count>=limit; dir=0 -> count==0.
REQ-016 SHALL have port wrap_pulse  out  1  registered, one cycle high after a terminal step.
REQ-017 SHALL have ports running, done  out  1 each  state==RUN, state==DONE.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DONE; step occurs only in RUN with en=1 and prescaler tick.
REQ-019 SHALL apply priority per cycle: clear > load > stop > start > step.
REQ-020 SHALL on clear set count=0 and prescaler=0, go to IDLE, and drive wrap_pulse=0.
REQ-021 SHALL on load set count=load_val and prescaler=0, leave state unchanged, and perform no step that cycle.
REQ-022 SHALL on start (from IDLE/DONE) go to RUN with prescaler=0; start in RUN is ignored; start with stop -> IDLE.
REQ-023 SHALL keep a prescaler that counts enabled RUN cycles 0..prescale, ticks at prescale, then returns to 0; prescale=0 ticks every enabled cycle; the prescaler holds when en=0.
REQ-024 SHALL step non-terminally: up -> count+1, down -> count-1.
REQ-025 SHALL on a terminal step (tc=1 at tick) in WRAP: up -> 0, down -> limit.
REQ-026 SHALL on a terminal step in SAT hold count unchanged.
REQ-027 SHALL on a terminal step in ONESHOT hold count and go to DONE.
REQ-028 SHALL assert wrap_pulse exactly one cycle after every terminal step in any mode, including repeated SAT hold ticks.
REQ-029 SHALL treat count>limit while counting up as terminal (tc=1), so an up-count never runs past limit.
REQ-030 SHALL sample limit, mode, dir and prescale every cycle; a change takes effect on the next tick.
REQ-031 SHALL, when limit=0 and dir=1, be terminal at every tick (WRAP keeps count at 0).

Reset
REQ-032 SHALL on reset_n low immediately force count=0, prescaler=0, state=IDLE, wrap_pulse=0, running=0, done=0.
REQ-033 SHALL release reset synchronously to clk; the first step is possible no earlier than the second edge after release, with start on the first.
REQ-034 SHALL, on reset mid-RUN, discard any pending prescaler progress.

Structure
REQ-035 SHALL place mode encodings (MODE_WRAP, MODE_SAT, MODE_ONESHOT) and state encodings in shared package prog_counter_pkg.
REQ-036 SHALL implement the prescaler as sub-module tick_gen (parameter PRE_W; ports clk, reset_n, clr, en, prescale, tick).
REQ-037 SHALL keep the top-level RUN/step logic in prog_counter, 120-400 lines total RTL.

Verification
REQ-038 SHALL cover WRAP up: WIDTH=8, limit=5, prescale=0, start, en=1 -> count 0,1,2,3,4,5,0; wrap_pulse one cycle after 5->0.
REQ-039 SHALL cover SAT down with prescale=2: load_val=2, dir=0 -> count 2,1,0 changing every 3rd cycle, then holds 0; wrap_pulse at each held tick.
REQ-040 SHALL cover ONESHOT: limit=3 from 0 -> reaches 3, next tick done=1, running=0, count=3; a following start -> RUN, restarts from held count (terminal, so DONE again at next tick).
REQ-041 SHALL cover priority: clear+load+start in one cycle -> count=0, IDLE; load during RUN at count=7, load_val=2 -> count=2, no step that cycle.
REQ-042 SHALL cover above-limit: load_val=200, limit=10, up WRAP -> tc=1, next tick count=0.
REQ-043 SHALL cover async reset mid-RUN at count=4 -> outputs zero/IDLE without a clk edge; start after release restarts prescaler from 0.
